// File: rtl/fifo_registers_gen2_if.sv
// Handshake/data bundle between a FIFO user (master) and fifo_registers_gen2 (slave).
// Latency: none (wires only).
// Backpressure: the slave reports o_Full/o_Empty; the master is expected to honour them.
// Ports: write side (i_Wr_En, i_Wr_Data, o_Full, o_AF), read side (i_Rd_En, o_Rd_Data,
//        o_Rd_Valid, o_Empty, o_AE), status (o_Count, i_Clr_Err, o_Overflow, o_Underflow).
interface fifo_registers_gen2_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   logic                       i_Wr_En;
   logic [WIDTH-1:0]           i_Wr_Data;
   logic                       o_Full;
   logic                       o_AF;
   logic                       i_Rd_En;
   logic [WIDTH-1:0]           o_Rd_Data;
   logic                       o_Rd_Valid;
   logic                       o_Empty;
   logic                       o_AE;
   logic [$clog2(DEPTH+1)-1:0] o_Count;
   logic                       i_Clr_Err;
   logic                       o_Overflow;
   logic                       o_Underflow;

   modport master (
      output i_Wr_En, i_Wr_Data, i_Rd_En, i_Clr_Err,
      input  o_Full, o_AF, o_Rd_Data, o_Rd_Valid, o_Empty, o_AE, o_Count,
             o_Overflow, o_Underflow
   );

   modport slave (
      input  i_Wr_En, i_Wr_Data, i_Rd_En, i_Clr_Err,
      output o_Full, o_AF, o_Rd_Data, o_Rd_Valid, o_Empty, o_AE, o_Count,
             o_Overflow, o_Underflow
   );
endinterface

// File: rtl/fifo_registers_gen2.sv
// Synchronous register-array FIFO, any DEPTH >= 2, optional first-word-fall-through.
// Latency: write visible next cycle; FWFT=0 read data registered one cycle after accepted read.
// Backpressure: writes rejected while full, reads rejected while empty; both set sticky errors.
// Ports: i_Clk, i_Rst_L (async active-low), bus (fifo_registers_gen2_if.slave).
module fifo_registers_gen2 #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 4,
   parameter int FWFT     = 0
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst_L,
   fifo_registers_gen2_if.slave    bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             wr_acc;
   logic             rd_acc;
   logic             ovf_q;
   logic             unf_q;

   // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Status flags decode only the count register, so no input reaches them combinationally.
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign wr_acc = bus.i_Wr_En & ~full;
   assign rd_acc = bus.i_Rd_En & ~empty;

   assign bus.o_Full      = full;
   assign bus.o_Empty     = empty;
   assign bus.o_AF        = (int'(count) >= AF_LEVEL);
   assign bus.o_AE        = (int'(count) <= AE_LEVEL);
   assign bus.o_Count     = count;
   assign bus.o_Overflow  = ovf_q;
   assign bus.o_Underflow = unf_q;

   // Storage carries no reset; validity is tracked entirely by the pointers and count.
   always_ff @(posedge i_Clk) begin
      if (wr_acc) mem[wr_ptr] <= bus.i_Wr_Data;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // A new error event takes priority over a coincident clear.
         if (bus.i_Wr_En && full)  ovf_q <= 1'b1;
         else if (bus.i_Clr_Err)   ovf_q <= 1'b0;
         if (bus.i_Rd_En && empty) unf_q <= 1'b1;
         else if (bus.i_Clr_Err)   unf_q <= 1'b0;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word shown straight from the array; valid whenever anything is stored.
         assign bus.o_Rd_Data  = mem[rd_ptr];
         assign bus.o_Rd_Valid = ~empty;
      end else begin : g_reg
         logic [WIDTH-1:0] rd_data_q;
         logic             rd_vld_q;

         always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
               rd_data_q <= '0;
               rd_vld_q  <= 1'b0;
            end else begin
               rd_vld_q <= rd_acc;
               if (rd_acc) rd_data_q <= mem[rd_ptr];
            end
         end

         assign bus.o_Rd_Data  = rd_data_q;
         assign bus.o_Rd_Valid = rd_vld_q;
      end
   endgenerate
endmodule

// File: tb/tb_fifo_registers_gen2.sv
module tb_fifo_registers_gen2;
   logic i_Clk;
   logic rst_l;
   int   checks;
   int   passed;

   fifo_registers_gen2_if #(.WIDTH(8), .DEPTH(5))  if5  ();
   fifo_registers_gen2_if #(.WIDTH(8), .DEPTH(5))  iffw ();
   fifo_registers_gen2_if #(.WIDTH(8), .DEPTH(16)) if16 ();

   fifo_registers_gen2 #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_d5 (
      .i_Clk(i_Clk), .i_Rst_L(rst_l), .bus(if5.slave));
   fifo_registers_gen2 #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u_fw (
      .i_Clk(i_Clk), .i_Rst_L(rst_l), .bus(iffw.slave));
   fifo_registers_gen2 #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) u_d16 (
      .i_Clk(i_Clk), .i_Rst_L(rst_l), .bus(if16.slave));

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic test_reset();
      rst_l = 1'b1;
      #2 rst_l = 1'b0;
      #1;
      checks++; if (if5.o_Empty !== 1'b1) $display("FAIL rst_empty got %b want 1", if5.o_Empty); else passed++;
      checks++; if (if5.o_Full !== 1'b0) $display("FAIL rst_full got %b want 0", if5.o_Full); else passed++;
      checks++; if (if5.o_Count !== 3'd0) $display("FAIL rst_count got %0d want 0", if5.o_Count); else passed++;
      checks++; if ({if5.o_AE, if5.o_AF} !== 2'b10) $display("FAIL rst_ae_af got %b want 10", {if5.o_AE, if5.o_AF}); else passed++;
      checks++; if ({if5.o_Rd_Valid, if5.o_Rd_Data} !== 9'h000) $display("FAIL rst_rd got %h want 000", {if5.o_Rd_Valid, if5.o_Rd_Data}); else passed++;
      checks++; if ({if5.o_Overflow, if5.o_Underflow} !== 2'b00) $display("FAIL rst_err got %b want 00", {if5.o_Overflow, if5.o_Underflow}); else passed++;
      checks++; if ({if16.o_Empty, if16.o_AE, if16.o_AF} !== 3'b110) $display("FAIL rst_d16 got %b want 110", {if16.o_Empty, if16.o_AE, if16.o_AF}); else passed++;
      @(negedge i_Clk);
      rst_l = 1'b1;
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 5; i++) begin
         if5.i_Wr_En = 1'b1; if5.i_Wr_Data = 8'(8'h11 * (i + 1));
         tick();
         checks++; if (if5.o_Count !== 3'(i + 1)) $display("FAIL fill_count got %0d want %0d", if5.o_Count, i + 1); else passed++;
      end
      checks++; if (if5.o_Full !== 1'b1) $display("FAIL fill_full got %b want 1", if5.o_Full); else passed++;
      if5.i_Wr_Data = 8'h66;
      tick();
      if5.i_Wr_En = 1'b0;
      checks++; if ({if5.o_Overflow, if5.o_Count} !== {1'b1, 3'd5}) $display("FAIL ovf got %b/%0d want 1/5", if5.o_Overflow, if5.o_Count); else passed++;
      for (int i = 0; i < 5; i++) begin
         if5.i_Rd_En = 1'b1;
         tick();
         if5.i_Rd_En = 1'b0;
         checks++; if ({if5.o_Rd_Valid, if5.o_Rd_Data} !== {1'b1, 8'(8'h11 * (i + 1))}) $display("FAIL drain_data got %b/%h want 1/%h", if5.o_Rd_Valid, if5.o_Rd_Data, 8'(8'h11 * (i + 1))); else passed++;
         tick();
         checks++; if ({if5.o_Rd_Valid, if5.o_Rd_Data} !== {1'b0, 8'(8'h11 * (i + 1))}) $display("FAIL drain_hold got %b/%h want 0/%h", if5.o_Rd_Valid, if5.o_Rd_Data, 8'(8'h11 * (i + 1))); else passed++;
      end
      checks++; if ({if5.o_Empty, if5.o_Underflow} !== 2'b10) $display("FAIL drain_empty got %b want 10", {if5.o_Empty, if5.o_Underflow}); else passed++;
      if5.i_Rd_En = 1'b1;
      tick();
      if5.i_Rd_En = 1'b0;
      checks++; if ({if5.o_Underflow, if5.o_Rd_Valid, if5.o_Count} !== {2'b10, 3'd0}) $display("FAIL unf got %b/%b/%0d want 1/0/0", if5.o_Underflow, if5.o_Rd_Valid, if5.o_Count); else passed++;
      if5.i_Clr_Err = 1'b1;
      tick();
      if5.i_Clr_Err = 1'b0;
      checks++; if ({if5.o_Overflow, if5.o_Underflow} !== 2'b00) $display("FAIL clr got %b want 00", {if5.o_Overflow, if5.o_Underflow}); else passed++;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 12; i++) begin
         if5.i_Wr_En = 1'b1; if5.i_Wr_Data = 8'(8'h30 + i);
         tick();
         if5.i_Wr_En = 1'b0;
         checks++; if (if5.o_Count !== 3'd1) $display("FAIL wrap_count got %0d want 1", if5.o_Count); else passed++;
         if5.i_Rd_En = 1'b1;
         tick();
         if5.i_Rd_En = 1'b0;
         checks++; if ({if5.o_Rd_Valid, if5.o_Rd_Data, if5.o_Count} !== {1'b1, 8'(8'h30 + i), 3'd0}) $display("FAIL wrap_data got %b/%h/%0d want 1/%h/0", if5.o_Rd_Valid, if5.o_Rd_Data, if5.o_Count, 8'(8'h30 + i)); else passed++;
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 5; i++) begin
         if5.i_Wr_En = 1'b1; if5.i_Wr_Data = 8'(8'hA0 + i);
         tick();
      end
      if5.i_Rd_En = 1'b1; if5.i_Wr_Data = 8'hEE;
      tick();
      if5.i_Wr_En = 1'b0; if5.i_Rd_En = 1'b0;
      checks++; if ({if5.o_Count, if5.o_Overflow, if5.o_Rd_Data} !== {3'd4, 1'b1, 8'hA0}) $display("FAIL simul_full got %0d/%b/%h want 4/1/a0", if5.o_Count, if5.o_Overflow, if5.o_Rd_Data); else passed++;
      for (int i = 1; i < 5; i++) begin
         if5.i_Rd_En = 1'b1;
         tick();
         if5.i_Rd_En = 1'b0;
         checks++; if (if5.o_Rd_Data !== 8'(8'hA0 + i)) $display("FAIL simul_drain got %h want %h", if5.o_Rd_Data, 8'(8'hA0 + i)); else passed++;
      end
      if5.i_Clr_Err = 1'b1;
      tick();
      if5.i_Clr_Err = 1'b0;
      if5.i_Wr_En = 1'b1; if5.i_Rd_En = 1'b1; if5.i_Wr_Data = 8'h77;
      tick();
      if5.i_Wr_En = 1'b0; if5.i_Rd_En = 1'b0;
      checks++; if ({if5.o_Count, if5.o_Underflow, if5.o_Overflow, if5.o_Rd_Valid} !== {3'd1, 3'b100}) $display("FAIL simul_empty got %0d/%b/%b/%b want 1/1/0/0", if5.o_Count, if5.o_Underflow, if5.o_Overflow, if5.o_Rd_Valid); else passed++;
      if5.i_Rd_En = 1'b1;
      tick();
      checks++; if ({if5.o_Rd_Valid, if5.o_Rd_Data} !== {1'b1, 8'h77}) $display("FAIL simul_read got %b/%h want 1/77", if5.o_Rd_Valid, if5.o_Rd_Data); else passed++;
      // Underflow event and clear in the same cycle: the event must win.
      if5.i_Clr_Err = 1'b1;
      tick();
      if5.i_Clr_Err = 1'b0; if5.i_Rd_En = 1'b0;
      checks++; if (if5.o_Underflow !== 1'b1) $display("FAIL set_beats_clr got %b want 1", if5.o_Underflow); else passed++;
   endtask

   task automatic test_fwft();
      checks++; if ({iffw.o_Rd_Valid, iffw.o_Empty} !== 2'b01) $display("FAIL fwft_idle got %b want 01", {iffw.o_Rd_Valid, iffw.o_Empty}); else passed++;
      iffw.i_Wr_En = 1'b1; iffw.i_Wr_Data = 8'hA5;
      tick();
      iffw.i_Wr_Data = 8'h5A;
      checks++; if ({iffw.o_Rd_Valid, iffw.o_Rd_Data} !== {1'b1, 8'hA5}) $display("FAIL fwft_first got %b/%h want 1/a5", iffw.o_Rd_Valid, iffw.o_Rd_Data); else passed++;
      tick();
      iffw.i_Wr_En = 1'b0;
      checks++; if ({iffw.o_Rd_Data, iffw.o_Count} !== {8'hA5, 3'd2}) $display("FAIL fwft_hold got %h/%0d want a5/2", iffw.o_Rd_Data, iffw.o_Count); else passed++;
      iffw.i_Rd_En = 1'b1;
      tick();
      checks++; if ({iffw.o_Rd_Valid, iffw.o_Rd_Data} !== {1'b1, 8'h5A}) $display("FAIL fwft_next got %b/%h want 1/5a", iffw.o_Rd_Valid, iffw.o_Rd_Data); else passed++;
      tick();
      iffw.i_Rd_En = 1'b0;
      checks++; if ({iffw.o_Empty, iffw.o_Rd_Valid} !== 2'b10) $display("FAIL fwft_empty got %b want 10", {iffw.o_Empty, iffw.o_Rd_Valid}); else passed++;
   endtask

   task automatic test_levels();
      for (int c = 0; c <= 16; c++) begin
         checks++;
         if ({if16.o_Count, if16.o_AE, if16.o_AF, if16.o_Full} !== {5'(c), c <= 4, c >= 12, c == 16})
            $display("FAIL levels c=%0d got cnt=%0d ae=%b af=%b full=%b", c, if16.o_Count, if16.o_AE, if16.o_AF, if16.o_Full);
         else passed++;
         if16.i_Wr_En = 1'b1; if16.i_Wr_Data = 8'(c);
         tick();
      end
      if16.i_Wr_En = 1'b0;
      checks++; if ({if16.o_Overflow, if16.o_Count} !== {1'b1, 5'd16}) $display("FAIL lvl_ovf got %b/%0d want 1/16", if16.o_Overflow, if16.o_Count); else passed++;
      if16.i_Clr_Err = 1'b1;
      tick();
      if16.i_Clr_Err = 1'b0;
      checks++; if (if16.o_Overflow !== 1'b0) $display("FAIL lvl_clr got %b want 0", if16.o_Overflow); else passed++;
      if16.i_Rd_En = 1'b1;
      repeat (7) tick();
      if16.i_Rd_En = 1'b0;
      checks++; if ({if16.o_Count, if16.o_Rd_Data} !== {5'd9, 8'd6}) $display("FAIL lvl_nine got %0d/%h want 9/06", if16.o_Count, if16.o_Rd_Data); else passed++;
      rst_l = 1'b0;
      #1;
      checks++; if ({if16.o_Count, if16.o_Empty, if16.o_AE} !== {5'd0, 2'b11}) $display("FAIL async_rst got %0d/%b/%b want 0/1/1", if16.o_Count, if16.o_Empty, if16.o_AE); else passed++;
      rst_l = 1'b1;
      if16.i_Wr_En = 1'b1; if16.i_Wr_Data = 8'h42;
      tick();
      if16.i_Wr_En = 1'b0;
      checks++; if (if16.o_Count !== 5'd1) $display("FAIL post_rst_wr got %0d want 1", if16.o_Count); else passed++;
      if16.i_Rd_En = 1'b1;
      tick();
      if16.i_Rd_En = 1'b0;
      checks++; if ({if16.o_Rd_Data, if16.o_Empty} !== {8'h42, 1'b1}) $display("FAIL post_rst_rd got %h/%b want 42/1", if16.o_Rd_Data, if16.o_Empty); else passed++;
   endtask

   initial begin
      checks = 0; passed = 0;
      if5.i_Wr_En = 1'b0;  if5.i_Rd_En = 1'b0;  if5.i_Clr_Err = 1'b0;  if5.i_Wr_Data = '0;
      iffw.i_Wr_En = 1'b0; iffw.i_Rd_En = 1'b0; iffw.i_Clr_Err = 1'b0; iffw.i_Wr_Data = '0;
      if16.i_Wr_En = 1'b0; if16.i_Rd_En = 1'b0; if16.i_Clr_Err = 1'b0; if16.i_Wr_Data = '0;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simultaneous();
      test_fwft();
      test_levels();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/fifo_registers_gen2.md
FIFO_REGISTERS_GEN2 -- requirements
Module: fifo_registers_gen2

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of words (>=2, not restricted to powers of two).
REQ-003 SHALL have parameter AF_LEVEL, default 12; o_AF asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 4; o_AE asserts when count <= AE_LEVEL.
REQ-005 SHALL have parameter FWFT, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port i_Clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port i_Rst_L  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port i_Wr_En  input  1  write request.
REQ-009 SHALL have port i_Wr_Data  input  WIDTH  write data.
REQ-010 SHALL have port o_Full  output  1  no free words.
REQ-011 SHALL have port o_AF  output  1  almost full.
REQ-012 SHALL have port i_Rd_En  input  1  read request.
REQ-013 SHALL have port o_Rd_Data  output  WIDTH  read data.
REQ-014 SHALL have port o_Rd_Valid  output  1  o_Rd_Data holds a valid popped/head word.
REQ-015 SHALL have port o_Empty  output  1  no stored words.
REQ-016 SHALL have port o_AE  output  1  almost empty.
REQ-017 SHALL have port o_Count  output  $clog2(DEPTH+1)  stored words, 0..DEPTH inclusive.
REQ-018 SHALL have port i_Clr_Err  input  1  synchronous clear of sticky error flags.
REQ-019 SHALL have port o_Overflow  output  1  sticky: write attempted while full.
REQ-020 SHALL have port o_Underflow  output  1  sticky: read attempted while empty.

Function
REQ-021 Write SHALL be accepted iff i_Wr_En=1 and o_Full=0; accepted word stored at write pointer, pointer advances.
REQ-022 Read SHALL be accepted iff i_Rd_En=1 and o_Empty=0; read pointer advances.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH.
REQ-024 o_Count SHALL update next cycle: +1 on write only, -1 on read only, unchanged on both or neither; rejected requests SHALL not change count, pointers or memory.
REQ-025 Simultaneous accepted read and write SHALL both complete; at count=0 only write is accepted, at count=DEPTH only read.
REQ-026 o_Full = (o_Count==DEPTH), o_Empty = (o_Count==0), o_AF, o_AE SHALL be decoded from registered count only, no combinational input paths.
REQ-027 FWFT=0: o_Rd_Data SHALL register the head word one cycle after an accepted read, o_Rd_Valid pulses high that cycle; o_Rd_Data holds between reads.
REQ-028 FWFT=1: o_Rd_Data SHALL show the head word combinationally from memory, o_Rd_Valid = not o_Empty; accepted read exposes the next word the following cycle.
REQ-029 Write to an empty FIFO SHALL be readable (FWFT=1: visible on o_Rd_Data) the cycle after acceptance.
REQ-030 o_Overflow SHALL set on i_Wr_En=1 while o_Full=1; o_Underflow SHALL set on i_Rd_En=1 while o_Empty=1; both hold until i_Clr_Err=1; a set event coincident with clear SHALL win.
REQ-031 Memory SHALL be a register array of DEPTH x WIDTH, no reset on contents.

Reset
REQ-032 i_Rst_L=0 SHALL immediately clear pointers, count, o_Rd_Valid, o_Rd_Data (FWFT=0), o_Overflow, o_Underflow, giving o_Empty=1, o_Full=0, o_AE=(AE_LEVEL>=0)=1, o_AF=0.
REQ-033 Reset asserted mid-operation SHALL discard all stored words; release SHALL be synchronous-safe, first accepted operation on the first rising edge after i_Rst_L=1.

Verification
REQ-034 WIDTH=8, DEPTH=5, FWFT=0: write 0x11..0x55 -> o_Full=1, o_Count=5; sixth write 0x66 -> rejected, o_Overflow=1; five reads -> 0x11..0x55 each one cycle after i_Rd_En with o_Rd_Valid pulses, then o_Empty=1.
REQ-035 DEPTH=5: 12 writes interleaved with 12 reads, alternating -> data order preserved across pointer wrap, o_Count never exceeds 1.
REQ-036 Count=5 (full), i_Wr_En=i_Rd_En=1 -> read accepted, write rejected, o_Count=4, o_Overflow=1; count=0 same stimulus -> write only, o_Count=1, o_Underflow=1.
REQ-037 FWFT=1: write 0xA5 to empty -> next cycle o_Rd_Data=0xA5, o_Rd_Valid=1 without i_Rd_En; read -> o_Empty=1, o_Rd_Valid=0.
REQ-038 DEPTH=16, AF_LEVEL=12, AE_LEVEL=4: fill 0..16 -> o_AE high for count<=4, o_AF high for count>=12; i_Clr_Err clears sticky flags; i_Rst_L=0 at count=9 -> o_Count=0, o_Empty=1 asynchronously.
